// File: rtl/xaddrgen2_if.sv
// Control, configuration and address bus of the xaddrgen2 sweep generator.
// The master drives the controls and config; the slave (the generator) returns addr/mem_en/done.
interface xaddrgen2_if #(
   parameter int unsigned MEM_ADDR_W = 10,
   parameter int unsigned PERIOD_W   = 10
);
   logic                  init;
   logic                  run;
   logic                  pause;
   logic [PERIOD_W-1:0]   delay;
   logic [PERIOD_W-1:0]   period;
   logic [PERIOD_W-1:0]   duty;
   logic [PERIOD_W-1:0]   iterations;
   logic [PERIOD_W-1:0]   iterations2;
   logic [MEM_ADDR_W-1:0] start;
   logic [MEM_ADDR_W-1:0] incr;
   logic [MEM_ADDR_W-1:0] shift;
   logic [MEM_ADDR_W-1:0] shift2;
   logic [MEM_ADDR_W-1:0] addr;
   logic                  mem_en;
   logic                  done;

   modport master (
      output init, run, pause, delay, period, duty, iterations, iterations2,
             start, incr, shift, shift2,
      input  addr, mem_en, done
   );

   modport slave (
      input  init, run, pause, delay, period, duty, iterations, iterations2,
             start, incr, shift, shift2,
      output addr, mem_en, done
   );
endinterface

// File: rtl/xaddrgen2.sv
// Three-level nested-loop address generator with start delay, duty gating and pause.
// Addresses are built from running bases (outer, middle, current); no multipliers.
module xaddrgen2 #(
   parameter int unsigned MEM_ADDR_W = 10,
   parameter int unsigned PERIOD_W   = 10
) (
   input  logic       clk,
   input  logic       rst,
   xaddrgen2_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StDelay, StRun} state_e;

   state_e                r_state;
   logic [PERIOD_W-1:0]   r_per_last, r_it_last, r_it2_last, r_duty, r_dly;
   logic [PERIOD_W-1:0]   r_i, r_j, r_k;
   logic [MEM_ADDR_W-1:0] r_incr, r_shift, r_shift2;
   logic [MEM_ADDR_W-1:0] r_base_k, r_base_j, r_cur, r_addr;
   logic                  r_mem_en, r_done;

   logic [PERIOD_W-1:0]   w_per_last, w_it_last, w_it2_last;
   logic [PERIOD_W-1:0]   w_i_n, w_j_n, w_k_n;
   logic [MEM_ADDR_W-1:0] w_base_k_n, w_base_j_n, w_cur_n;
   logic                  w_i_wrap, w_j_wrap, w_final, w_launch, w_en_n;

   // A zero count behaves as a count of one.
   function automatic logic [PERIOD_W-1:0] last_of(input logic [PERIOD_W-1:0] n);
      return (n == '0) ? '0 : n - PERIOD_W'(1);
   endfunction

   assign w_per_last = last_of(bus.period);
   assign w_it_last  = last_of(bus.iterations);
   assign w_it2_last = last_of(bus.iterations2);

   assign w_i_wrap = (r_i == r_per_last);
   assign w_j_wrap = (r_j == r_it_last);
   assign w_final  = w_i_wrap && w_j_wrap && (r_k == r_it2_last);
   assign w_launch = bus.run && ((r_state == StIdle) ||
                                 ((r_state == StRun) && w_final && !bus.pause));
   // i never exceeds period-1, so i < duty already clips duty to period.
   assign w_en_n   = (w_i_n < r_duty);

   always_comb begin
      w_i_n      = r_i + PERIOD_W'(1);
      w_j_n      = r_j;
      w_k_n      = r_k;
      w_base_k_n = r_base_k;
      w_base_j_n = r_base_j;
      w_cur_n    = r_cur + r_incr;
      if (w_i_wrap) begin
         w_i_n = '0;
         if (!w_j_wrap) begin
            w_j_n      = r_j + PERIOD_W'(1);
            w_base_j_n = r_base_j + r_shift;
            w_cur_n    = w_base_j_n;
         end else begin
            w_j_n      = '0;
            w_k_n      = r_k + PERIOD_W'(1);
            w_base_k_n = r_base_k + r_shift2;
            w_base_j_n = w_base_k_n;
            w_cur_n    = w_base_k_n;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= StIdle;
         r_per_last <= '0;
         r_it_last  <= '0;
         r_it2_last <= '0;
         r_duty     <= '0;
         r_dly      <= '0;
         r_i        <= '0;
         r_j        <= '0;
         r_k        <= '0;
         r_incr     <= '0;
         r_shift    <= '0;
         r_shift2   <= '0;
         r_base_k   <= '0;
         r_base_j   <= '0;
         r_cur      <= '0;
         r_addr     <= '0;
         r_mem_en   <= 1'b0;
         r_done     <= 1'b1;
      end else if (w_launch) begin
         // Fresh sweep from IDLE, or back-to-back restart from the final RUN cycle.
         r_per_last <= w_per_last;
         r_it_last  <= w_it_last;
         r_it2_last <= w_it2_last;
         r_duty     <= bus.duty;
         r_incr     <= bus.incr;
         r_shift    <= bus.shift;
         r_shift2   <= bus.shift2;
         r_i        <= '0;
         r_j        <= '0;
         r_k        <= '0;
         r_base_k   <= bus.start;
         r_base_j   <= bus.start;
         r_cur      <= bus.start;
         r_done     <= 1'b0;
         if ((r_state == StIdle) && (bus.delay != '0)) begin
            r_state  <= StDelay;
            r_dly    <= bus.delay - PERIOD_W'(1);
            r_mem_en <= 1'b0;
         end else begin
            r_state  <= StRun;
            r_mem_en <= (bus.duty != '0);
            if (bus.duty != '0) r_addr <= bus.start;
         end
      end else begin
         unique case (r_state)
            StIdle: begin
               if (bus.init) begin
                  r_base_k <= bus.start;
                  r_base_j <= bus.start;
                  r_cur    <= bus.start;
                  r_addr   <= bus.start;
               end
            end
            StDelay: begin
               if (!bus.pause) begin
                  if (r_dly == '0) begin
                     r_state  <= StRun;
                     r_mem_en <= (r_duty != '0);
                     if (r_duty != '0) r_addr <= r_cur;
                  end else begin
                     r_dly <= r_dly - PERIOD_W'(1);
                  end
               end
            end
            StRun: begin
               if (bus.pause) begin
                  r_mem_en <= 1'b0;
               end else if (w_final) begin
                  r_state  <= StIdle;
                  r_mem_en <= 1'b0;
                  r_done   <= 1'b1;
               end else begin
                  r_i      <= w_i_n;
                  r_j      <= w_j_n;
                  r_k      <= w_k_n;
                  r_base_k <= w_base_k_n;
                  r_base_j <= w_base_j_n;
                  r_cur    <= w_cur_n;
                  r_mem_en <= w_en_n;
                  if (w_en_n) r_addr <= w_cur_n;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.addr   = r_addr;
   assign bus.mem_en = r_mem_en;
   assign bus.done   = r_done;
endmodule
